// File: rtl/operand_stack_pkg.sv
// Shared definitions for the stack-MIPS operand stack: default geometry and the
// controller's two-bit stack operation encoding ({pop, push}).
package operand_stack_pkg;

  localparam int STACK_WIDTH = 8;
  localparam int STACK_DEPTH = 16;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_REPL = 2'b11
  } stack_op_e;

endpackage

// File: rtl/operand_stack.sv
// LIFO operand stack exposing top and next-on-stack for single-cycle binary ops,
// with sticky overflow/underflow flags for the controller.
module operand_stack
  import operand_stack_pkg::*;
#(
  parameter int WIDTH = STACK_WIDTH,
  parameter int DEPTH = STACK_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       clr_err,
  output logic [WIDTH-1:0]           tos,
  output logic [WIDTH-1:0]           nos,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       ovf,
  output logic                       udf
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    count_reg;
  logic             ovf_reg;
  logic             udf_reg;
  stack_op_e        op;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    top_addr;
  logic [AW-1:0]    below_addr;

  assign op         = stack_op_e'({pop, push});
  assign empty      = (count_reg == '0);
  assign full       = (count_reg == DEPTH_C);
  assign top_addr   = AW'(count_reg - CW'(1));
  assign below_addr = AW'(count_reg - CW'(2));

  // Push writes the free slot above top; replace-top overwrites the top slot.
  assign wr_en   = ((op == OP_PUSH) && !full) || ((op == OP_REPL) && !empty);
  assign wr_addr = (op == OP_PUSH) ? AW'(count_reg) : top_addr;

  // Storage is never reset; stale entries are hidden by the count-based masking below.
  always_ff @(posedge clk) begin
    if (rst && wr_en) begin
      mem[wr_addr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
      ovf_reg   <= 1'b0;
      udf_reg   <= 1'b0;
    end else begin
      if (clr_err) begin
        ovf_reg <= 1'b0;
        udf_reg <= 1'b0;
      end
      // Errors raised this cycle are assigned last so they win over clr_err.
      case (op)
        OP_PUSH: begin
          if (full) ovf_reg <= 1'b1;
          else      count_reg <= count_reg + CW'(1);
        end
        OP_POP: begin
          if (empty) udf_reg <= 1'b1;
          else       count_reg <= count_reg - CW'(1);
        end
        OP_REPL: begin
          if (empty) udf_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign tos   = empty ? '0 : mem[top_addr];
  assign nos   = (count_reg < CW'(2)) ? '0 : mem[below_addr];
  assign count = count_reg;
  assign ovf   = ovf_reg;
  assign udf   = udf_reg;

endmodule

// File: tb/tb_operand_stack.sv
// Scoreboard bench for operand_stack: a queue-based LIFO model predicts every cycle's
// outputs, and a monitor on the falling edge compares them against the DUT.
module tb_operand_stack;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic [WIDTH-1:0] push_data = '0;
  logic             clr_err = 1'b0;
  logic [WIDTH-1:0] tos;
  logic [WIDTH-1:0] nos;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             ovf;
  logic             udf;

  operand_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (push_data),
    .clr_err   (clr_err),
    .tos       (tos),
    .nos       (nos),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .ovf       (ovf),
    .udf       (udf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int  tos;
    int  nos;
    int  count;
    bit  empty;
    bit  full;
    bit  ovf;
    bit  udf;
    int  txn;
  } exp_t;

  exp_t exp_q[$];
  int   model[$];
  bit   m_ovf;
  bit   m_udf;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_txn    = 0;

  task automatic check(string name, int act, int req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    e.count = model.size();
    e.tos   = (model.size() > 0) ? model[model.size()-1] : 0;
    e.nos   = (model.size() > 1) ? model[model.size()-2] : 0;
    e.empty = (model.size() == 0);
    e.full  = (model.size() == DEPTH);
    e.ovf   = m_ovf;
    e.udf   = m_udf;
    e.txn   = n_txn;
    return e;
  endfunction

  // Reference behaviour: clear first, then any error raised this cycle sets its flag.
  function automatic void model_step(bit p, bit q, int d, bit c);
    if (c) begin
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end
    if (p && !q) begin
      if (model.size() == DEPTH) m_ovf = 1'b1;
      else model.push_back(d);
    end else if (!p && q) begin
      if (model.size() == 0) m_udf = 1'b1;
      else void'(model.pop_back());
    end else if (p && q) begin
      if (model.size() == 0) m_udf = 1'b1;
      else model[model.size()-1] = d;
    end
  endfunction

  task automatic do_op(bit p, bit q, int d, bit c);
    push = p; pop = q; push_data = WIDTH'(d); clr_err = c;
    @(posedge clk);
    n_txn++;
    model_step(p, q, d, c);
    exp_q.push_back(snapshot());
    #1;
    push = 1'b0; pop = 1'b0; clr_err = 1'b0;
  endtask

  // Monitor: one expected record per clock edge driven by the stimulus process.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        $display("txn %0d: push=%0b pop=%0b cnt=%0d tos=%02h nos=%02h ovf=%0b udf=%0b",
                 e.txn, dut.push, dut.pop, count, tos, nos, ovf, udf);
        check("tos",   int'(tos),   e.tos);
        check("nos",   int'(nos),   e.nos);
        check("count", int'(count), e.count);
        check("empty", int'(empty), int'(e.empty));
        check("full",  int'(full),  int'(e.full));
        check("ovf",   int'(ovf),   int'(e.ovf));
        check("udf",   int'(udf),   int'(e.udf));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    m_ovf = 1'b0;
    m_udf = 1'b0;

    // Reset state while rst is held low
    #1;
    check("rst_count", int'(count), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_full",  int'(full),  0);
    check("rst_flags", int'({ovf, udf}), 0);
    check("rst_tos",   int'(tos), 0);
    #11 rst = 1'b1;

    // Pushes then pops, underflow on empty
    do_op(1, 0, 'h11, 0);
    do_op(1, 0, 'h22, 0);
    do_op(1, 0, 'h33, 0);
    check("t1_tos", int'(tos), 'h33);
    check("t1_nos", int'(nos), 'h22);
    do_op(0, 1, 0, 0);
    do_op(0, 1, 0, 0);
    check("t2_tos", int'(tos), 'h11);
    do_op(0, 1, 0, 0);
    do_op(0, 1, 0, 0);
    check("t2_udf", int'(udf), 1);
    check("t2_count", int'(count), 0);

    // Fill to capacity, then overflow
    for (int i = 0; i < DEPTH; i++) do_op(1, 0, i, 0);
    do_op(1, 0, 'hAA, 0);
    check("t3_ovf", int'(ovf), 1);
    check("t3_tos", int'(tos), 'h0F);

    // Error clearing, and an error in the same cycle winning over clear
    do_op(0, 0, 0, 1);
    check("t5_clr", int'(ovf), 0);
    do_op(1, 0, 'hBB, 1);
    check("t5_win", int'(ovf), 1);
    do_op(1, 1, 'h5A, 0);
    check("t5_repl_full_no_ovf", int'(count), DEPTH);

    // Binary op: two operands replaced by one result
    for (int i = 0; i < DEPTH; i++) do_op(0, 1, 0, 1);
    do_op(1, 0, 'h05, 0);
    do_op(1, 0, 'h07, 0);
    do_op(0, 1, 0, 0);
    do_op(1, 1, 'h0C, 0);
    check("t4_tos", int'(tos), 'h0C);
    check("t4_count", int'(count), 1);
    do_op(0, 1, 0, 0);
    do_op(1, 1, 'h99, 0);
    check("t4_udf", int'(udf), 1);

    // Random traffic, first push-heavy then pop-heavy
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 9);
      if (i < 250) begin
        if (r < 5)      do_op(1, 0, $urandom_range(0, 255), ($urandom_range(0, 15) == 0));
        else if (r < 7) do_op(0, 1, 0, ($urandom_range(0, 15) == 0));
        else if (r < 9) do_op(1, 1, $urandom_range(0, 255), ($urandom_range(0, 15) == 0));
        else            do_op(0, 0, 0, ($urandom_range(0, 3) == 0));
      end else begin
        if (r < 3)      do_op(1, 0, $urandom_range(0, 255), ($urandom_range(0, 15) == 0));
        else if (r < 7) do_op(0, 1, 0, ($urandom_range(0, 15) == 0));
        else if (r < 9) do_op(1, 1, $urandom_range(0, 255), ($urandom_range(0, 15) == 0));
        else            do_op(0, 0, 0, ($urandom_range(0, 3) == 0));
      end
    end

    // Asynchronous reset between edges takes effect without a clock edge
    do_op(1, 0, 'h44, 0);
    #6;
    rst = 1'b0;
    #1;
    model.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    check("t6_count", int'(count), 0);
    check("t6_tos",   int'(tos), 0);
    check("t6_empty", int'(empty), 1);
    check("t6_flags", int'({ovf, udf}), 0);
    rst = 1'b1;
    do_op(1, 0, 'h66, 0);
    do_op(0, 0, 0, 0);

    @(negedge clk);
    #1;
    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
